// File: rtl/divrem_pkg.sv
// Shared definitions for the sequential divide/remainder engine:
// FSM encoding, default operand width and iteration count.
package divrem_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DIV_ITERS = DEF_XLEN;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/divrem_step.sv
// One restoring radix-2 iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep or restore the partial remainder.
module divrem_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] part_rem,
    input  logic            dvd_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] part_rem_next,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // part_rem < divisor, so the XLEN+1 bit difference never wraps and
    // its MSB is a valid sign.
    always_comb begin
        shifted       = {part_rem, dvd_msb};
        trial         = shifted - {1'b0, divisor};
        q_bit         = ~trial[XLEN];
        part_rem_next = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/divrem_seq.sv
// Sequential 32-cycle restoring divider with RISC-V DIV/DIVU/REM/REMU
// semantics; results are held until the next completion.
module divrem_seq
    import divrem_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic            clk,
    input  logic            cpurst_n,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divider,
    input  logic            divsigned,
    input  logic            diven_p,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem,
    output logic            diven,
    output logic            divout_valid
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  pr_q, pr_d;
    logic [XLEN-1:0]  dvd_q, dvd_d;
    logic [XLEN-1:0]  dsr_q, dsr_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;

    logic [XLEN-1:0]  a_abs, b_abs;
    logic [XLEN-1:0]  pr_next;
    logic             q_bit;
    logic [XLEN-1:0]  qmag;
    logic             div_zero;
    logic             last_iter;

    divrem_step #(.XLEN(XLEN)) u_step (
        .part_rem      (pr_q),
        .dvd_msb       (dvd_q[XLEN-1]),
        .divisor       (dsr_q),
        .part_rem_next (pr_next),
        .q_bit         (q_bit)
    );

    always_comb begin
        a_abs     = (divsigned & dividend[XLEN-1]) ? -dividend : dividend;
        b_abs     = (divsigned & divider[XLEN-1])  ? -divider  : divider;
        div_zero  = (divider == '0);
        last_iter = (cnt_q == LAST_CNT);
        qmag      = {dvd_q[XLEN-2:0], q_bit};
    end

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (diven_p) state_d = div_zero ? ST_DONE : ST_CALC;
            ST_CALC: if (last_iter) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        diven        = (state_q == ST_CALC);
        divout_valid = (state_q == ST_DONE);
    end

    // Datapath: operand capture in IDLE, one quotient bit per CALC cycle,
    // result registers only written on the way into DONE.
    always_comb begin
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (diven_p) begin
                    if (div_zero) begin
                        quo_d = '1;
                        rem_d = dividend;
                    end else begin
                        dvd_d   = a_abs;
                        dsr_d   = b_abs;
                        qsign_d = divsigned & (dividend[XLEN-1] ^ divider[XLEN-1]);
                        rsign_d = divsigned & dividend[XLEN-1];
                        pr_d    = '0;
                        cnt_d   = '0;
                    end
                end
            end
            ST_CALC: begin
                pr_d  = pr_next;
                dvd_d = qmag;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    quo_d = qsign_q ? -qmag : qmag;
                    rem_d = rsign_q ? -pr_next : pr_next;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            cnt_q   <= '0;
            pr_q    <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    assign quo = quo_q;
    assign rem = rem_q;

endmodule

// File: doc/divrem_seq.md
# divrem_seq

Sequential 32-bit integer divide/remainder engine that services the execute stage's divide requests. It is the responder side of the divide handshake: it samples the operands on a one-cycle `diven_p` start pulse and holds `diven` high while it iterates, one quotient bit per cycle. It then pulses `divout_valid` and holds both quotient and remainder until the next completion, so a following REM/DIV can reuse the result of a fused pair. It handles RISC-V M-extension DIV/DIVU/REM/REMU semantics, including divide-by-zero and signed overflow.

## Interface
- `XLEN`, 32: operand/result width.
- `clk`  in  1  clock, all state on rising edge.
- `cpurst_n`  in  1  reset, asynchronous assert, active-low.
- `dividend`  in  XLEN  numerator (rs1); sampled only on accepted start.
- `divider`  in  XLEN  denominator (rs2); sampled only on accepted start.
- `divsigned`  in  1  1 = two's-complement operands (DIV/REM); 0 = unsigned.
- `diven_p`  in  1  start pulse; accepted only in IDLE.
- `quo`  out  XLEN  quotient; registered, held until the next completion.
- `rem`  out  XLEN  remainder; registered, held until the next completion.
- `diven`  out  1  busy; high while iterating (CALC).
- `divout_valid`  out  1  one-cycle completion pulse; `quo`/`rem` are valid from this cycle on.

## Operation
- FSM states: IDLE, CALC, DONE. Reset → IDLE; `quo`=0, `rem`=0, `diven`=0, `divout_valid`=0, counter=0.
- IDLE + `diven_p`=1, `divider`≠0: latch |dividend| and |divider|. Absolute value is taken only when `divsigned`=1 and the MSB is set. Latch quotient sign = `divsigned`&(a[31]^b[31]) and remainder sign = `divsigned`&a[31]. Clear the partial remainder, set counter=0, go to CALC.
- IDLE + `diven_p`=1, `divider`=0 (fast path): load `quo`=all ones and `rem`=`dividend` unchanged (either signedness). Go to DONE.
- CALC, restoring radix-2, per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor in XLEN+1 bits. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter increments. After the iteration with counter = XLEN-1, register the sign-corrected results into `quo`/`rem` and go to DONE.
- Sign correction: negate the magnitude quotient if the quotient sign is set; negate the magnitude remainder if the remainder sign is set.
- Overflow (-2^31 / -1, signed) needs no special case. The magnitude quotient 0x80000000 with positive sign gives `quo`=0x80000000 and `rem`=0.
- DONE: `divout_valid`=1 for exactly one cycle, then unconditionally back to IDLE.
- `diven_p` in CALC or DONE is ignored. Operands changing after acceptance have no effect.
- `quo`/`rem` change only on entry to DONE or on reset. They never change in IDLE or CALC.
- Reset mid-operation: FSM → IDLE and all outputs cleared immediately (asynchronous). No completion pulse follows.

## Timing
- Normal path, with `diven_p` sampled at edge E0:
  - `diven`=1 from E0 through E32 (32 cycles).
  - `divout_valid`=1 in the cycle after E32. Latency is 33 cycles from start to valid.
- Divide-by-zero path: `diven` stays 0 and `divout_valid`=1 in the cycle after E0. Latency is 1 cycle.
- `diven` and `divout_valid` are never both high.
- The earliest next start is the cycle after `divout_valid`, because the requester gates on !`diven` & !`divout_valid`.
- No combinational path from any input to any output.

## Structure
- Shared package `divrem_pkg`: FSM state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2), `XLEN` default, iteration count constant `DIV_ITERS`=XLEN.
- Counter width is $clog2(XLEN).
- One sub-module, `divrem_step`: combinational shift / trial-subtract / select for one iteration. Inputs are the partial remainder, dividend MSB and divisor; outputs are the next partial remainder and the quotient bit.
- The FSM, the sign/abs logic and the result registers live in `divrem_seq`.

## Test plan
- Unsigned 100 / 7, `divsigned`=0 → `diven` high 32 cycles; `divout_valid` at cycle 33 with `quo`=14, `rem`=2.
- Signed -7 / 2 (0xFFFFFFF9 / 2) → `quo`=0xFFFFFFFD, `rem`=0xFFFFFFFF. Signed 7 / -2 → `quo`=0xFFFFFFFD, `rem`=1.
- Divide by zero: 0xDEAD / 0, both signed and unsigned → `divout_valid` in the cycle after start, `diven` never high, `quo`=0xFFFFFFFF, `rem`=0xDEAD.
- 0x80000000 / 0xFFFFFFFF → signed: `quo`=0x80000000, `rem`=0. Unsigned: `quo`=0, `rem`=0x80000000.
- Start 100/7, then pulse `diven_p` with 9/3 at cycle 10 → the second pulse is ignored and the result is 14/2. After completion, hold `diven_p` low for 20 cycles → `quo`/`rem` stay 14/2.
- Assert `cpurst_n`=0 at cycle 15 of a division → all outputs 0 immediately. After release there is no `divout_valid`, and a new start of 9/3 completes with `quo`=3, `rem`=0.
